// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - request/response bundle between the core memory port and mem_responder
interface mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - wait-state memory responder for the core's unified memory port
// Optional access statistics counters are enabled with `define MEM_STATS_EN.
module mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mem_responder_if.slave       bus
`ifdef MEM_STATS_EN
    ,
    output logic [15:0]          stat_reads,
    output logic [15:0]          stat_writes,
    output logic [15:0]          stat_errs
`endif
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_cnt;
    logic        r_write;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic          w_accept;
    logic          w_access;
    logic          w_bad;
    logic [AW-1:0] w_idx;

    assign w_accept = (r_state == S_IDLE) && bus.req_valid;
    assign w_access = (r_state == S_WAIT) && (r_cnt == 4'd0);
    // Full-address decode: any bit above the array span flags an error rather than aliasing.
    assign w_bad    = (r_addr[1:0] != 2'b00) || (|r_addr[31:AW+2]);
    assign w_idx    = r_addr[AW+1:2];

    assign bus.req_ready = (r_state == S_IDLE);
    assign bus.rsp_valid = (r_state == S_RESP);
    assign bus.rsp_rdata = r_rdata;
    assign bus.rsp_err   = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (bus.req_valid) w_next_state = S_WAIT;
            S_WAIT: if (r_cnt == 4'd0) w_next_state = S_RESP;
            S_RESP: if (bus.rsp_ready) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= 4'd0;
            r_write <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_be    <= 4'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cnt   <= 4'(WAIT_CYCLES);
                r_write <= bus.req_write;
                r_addr  <= bus.req_addr;
                r_wdata <= bus.req_wdata;
                r_be    <= bus.req_be;
            end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_access) begin
                r_err   <= w_bad;
                r_rdata <= (w_bad || r_write) ? 32'd0 : r_mem[w_idx];
            end
        end
    end

    // Storage has no reset; an aborted transaction never reaches S_WAIT's access edge.
    always_ff @(posedge clk) begin
        if (w_access && r_write && !w_bad) begin
            for (int i = 0; i < 4; i++) begin
                if (r_be[i]) r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
            end
        end
    end

`ifdef MEM_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_reads  <= 16'd0;
            stat_writes <= 16'd0;
            stat_errs   <= 16'd0;
        end else if (w_access) begin
            if (w_bad) begin
                if (stat_errs != 16'hFFFF) stat_errs <= stat_errs + 16'd1;
            end else if (r_write) begin
                if (stat_writes != 16'hFFFF) stat_writes <= stat_writes + 16'd1;
            end else begin
                if (stat_reads != 16'hFFFF) stat_reads <= stat_reads + 16'd1;
            end
        end
    end
`endif

endmodule
